shift_issue_unit: RTL and testbench
===================================

# shift_issue_unit

Two-stage pipelined execute-stage front end for the ALU shifter. Decodes a MIPS shift instruction (funct, rotate flag, shamt, rs, rt) into the shifter's `shift_op`/`SA`/`data` controls in a registered issue stage. It then captures the shifter's combinational result into an output register. Valid/ready handshakes on both sides allow stalls without losing or duplicating operations.

## Interface
- No parameters; datapath fixed at 32 bits, shift amount 5 bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: upstream operation present.
- `in_ready` out 1: unit accepts the operation this cycle.
- `funct` in 6: MIPS funct field.
- `rot` in 1: the instruction's rotate bit. With SRL/SRLV it selects ROR; with SLL/SLLV it selects ROL. Ignored otherwise.
- `shamt` in 5: immediate shift amount.
- `rs_val` in 32: variable shift amount source; only bits [4:0] are used.
- `rt_val` in 32: operand to shift.
- `shift_op` out 2: to shifter; 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- `SA` out 5: to shifter.
- `data` out 32: to shifter.
- `result` in 32: from shifter, combinational on `shift_op`/`SA`/`data`.
- `out_valid` out 1: result register holds a valid entry.
- `out_ready` in 1: downstream accepts.
- `out_result` out 32: registered shift result.
- `out_illegal` out 1: entry came from an unsupported funct.

## Operation
- Decode (combinational, at accept):
  - 000000 SLL: `shift_op`=00, amt=`shamt`.
  - 000010 SRL: `shift_op`=01, amt=`shamt`.
  - 000011 SRA: `shift_op`=10, amt=`shamt`.
  - 000100 SLLV: `shift_op`=00, amt=`rs_val[4:0]`.
  - 000110 SRLV: `shift_op`=01, amt=`rs_val[4:0]`.
  - 000111 SRAV: `shift_op`=10, amt=`rs_val[4:0]`.
- Rotates:
  - `rot`=1 with SRL/SRLV: `shift_op`=11, `SA`=amt.
  - `rot`=1 with SLL/SLLV (ROL): `shift_op`=11, `SA`=(32−amt) mod 32, computed as 5-bit two's complement of amt. amt=0 gives `SA`=0.
- Any other funct: illegal. Register `shift_op`=00, `SA`=0, `data`=0, illegal flag=1.
- Stage 1 (issue register): holds `s1_valid`, `shift_op`, `SA`, `data`=`rt_val`, illegal. It drives the shifter ports directly from registers.
- Stage 2 (output register) loads on advance:
  - `out_result` = `result`, or 0 when illegal.
  - `out_illegal` = the stage-1 illegal flag.
- Advance rules:
  - s2_load = `s1_valid` && (!`out_valid` || `out_ready`).
  - `in_ready` = !`s1_valid` || s2_load. It is combinational and depends on `out_ready`.
  - s1 loads when `in_valid` && `in_ready`; otherwise s1 clears when s2_load.
  - `out_valid` sets on s2_load; it clears when `out_ready` && !s2_load.
- Stage 1 registers hold their values while stalled, so shifter inputs are stable and the result is recomputed identically.

## Timing
- Reset (async, immediate): `s1_valid`=0, `out_valid`=0, `shift_op`=00, `SA`=0, `data`=0, `out_result`=0, `out_illegal`=0. After reset deasserts, `in_ready`=1.
- Latency: op accepted at edge N → `out_valid`=1 after edge N+1.
- Throughput: 1 op/cycle with `out_ready` held high.
- Full pipeline (both stages valid, `out_ready`=0): `in_ready`=0; all state holds.
- `out_ready`=1 with both stages full: on that edge s2 takes s1, and s1 takes a new op if `in_valid`. No bubble.
- Simultaneous accept and drain are legal every cycle.
- Reset mid-operation discards both stages; no output is produced for in-flight ops.
- Output payload is stable while `out_valid` && !`out_ready`.

## Test plan
- SLL: `rt_val`=0x00000001, `shamt`=4 → `out_result`=0x00000010, `out_illegal`=0, `out_valid` 2 edges after accept.
- SRAV: `rs_val`=0x00000023 (amt 3), `rt_val`=0x80000000 → `shift_op`=10, `SA`=3, `out_result`=0xF0000000.
- Rotates on `rt_val`=0x12345678:
  - ROR (funct 000010, `rot`=1, `shamt`=8) → 0x78123456.
  - ROL (funct 000000, `rot`=1, `shamt`=8) → `SA`=24, 0x34567812.
  - ROL with `shamt`=0 → `SA`=0, 0x12345678.
- Backpressure: stream 4 SLL ops (amounts 1..4 on 0x1) with `out_ready` low for 3 cycles after the first result.
  - Expect `in_ready`=0 once both stages fill.
  - Held output stays stable.
  - Results 0x2, 0x4, 0x8, 0x10 appear in order, none lost or duplicated.
- Illegal funct 0x20 → `out_illegal`=1, `out_result`=0. The following legal op is unaffected.
- Assert `reset` with both stages full → `out_valid`, `s1_valid`, and all outputs go to 0 before the next edge. After release, a new SRL of 0x80000000 by 31 → 0x00000001.

Source files
------------

// File: rtl/shift_issue_unit.sv
// shift_issue_unit: two-stage issue/capture pipeline feeding an external ALU shifter
module shift_issue_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic        rot,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [1:0]  shift_op,
  output logic [4:0]  SA,
  output logic [31:0] data,
  input  logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_illegal
);
  logic        s1_valid, s1_illegal, s2_load, legal, left, right;
  logic [4:0]  amt, d_sa;
  logic [1:0]  d_op;
  always_comb begin
    legal = funct[5:3] == 3'b000 && funct[1:0] != 2'b01;
    left = funct[1:0] == 2'b00;
    right = funct[1:0] == 2'b10;
    amt = funct[2] ? rs_val[4:0] : shamt;
    d_op = !legal ? 2'b00 : rot && (left || right) ? 2'b11 : funct[1:0] == 2'b11 ? 2'b10 : right ? 2'b01 : 2'b00;
    d_sa = !legal ? 5'd0 : rot && left ? ~amt + 5'd1 : amt;
    s2_load = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_load;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_illegal <= 1'b0;
      shift_op <= 2'b00;
      SA <= 5'd0;
      data <= 32'd0;
      out_valid <= 1'b0;
      out_result <= 32'd0;
      out_illegal <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_illegal <= !legal;
        shift_op <= d_op;
        SA <= d_sa;
        data <= legal ? rt_val : 32'd0;
      end else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) begin
        out_valid <= 1'b1;
        out_result <= s1_illegal ? 32'd0 : result;
        out_illegal <= s1_illegal;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_issue_unit.sv
// tb_shift_issue_unit: vector table, corner sequences and randomized reference-model check
module tb_shift_issue_unit;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, rot = 0, out_valid, out_ready = 1, out_illegal;
  logic [5:0]  funct = 0;
  logic [4:0]  shamt = 0, SA;
  logic [31:0] rs_val = 0, rt_val = 0, data, result, out_result;
  logic [1:0]  shift_op;
  logic [63:0] rw;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [5:0]  funct;
    logic        rot;
    logic [4:0]  shamt;
    logic [31:0] rs, rt;
    logic [1:0]  op;
    logic [4:0]  sa;
    logic [31:0] res;
    logic        ill;
  } vec_t;
  vec_t vt[12];
  logic [32:0] q[$];
  always #5 clk = ~clk;
  shift_issue_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct(funct), .rot(rot),
    .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .shift_op(shift_op), .SA(SA), .data(data),
    .result(result), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_illegal(out_illegal)
  );
  always_comb begin
    rw = {data, data} >> SA;
    result = shift_op == 2'b00 ? data << SA : shift_op == 2'b01 ? data >> SA :
             shift_op == 2'b10 ? 32'($signed(data) >>> SA) : rw[31:0];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [5:0] f, input logic r, input logic [4:0] sh,
                                        input logic [31:0] rs, input logic [31:0] rt);
    int a;
    logic [63:0] w;
    a = f[2] ? int'(rs[4:0]) : int'(sh);
    w = {rt, rt};
    case (f)
      6'd0, 6'd4: return r ? {1'b0, 32'((w << a) >> 32)} : {1'b0, rt << a};
      6'd2, 6'd6: return r ? {1'b0, 32'(w >> a)} : {1'b0, rt >> a};
      6'd3, 6'd7: return {1'b0, 32'($signed(rt) >>> a)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction
  task automatic run_vec(input vec_t v, input string tag);
    in_valid = 1; funct = v.funct; rot = v.rot; shamt = v.shamt; rs_val = v.rs; rt_val = v.rt; out_ready = 1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    chk({tag, "_op"}, 32'(shift_op), 32'(v.op));
    chk({tag, "_sa"}, 32'(SA), 32'(v.sa));
    chk({tag, "_data"}, data, v.ill ? 32'd0 : v.rt);
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, out_result, v.res);
    chk({tag, "_ill"}, 32'(out_illegal), 32'(v.ill));
    @(posedge clk); #1;
  endtask
  initial begin
    int k, got, lowcnt, stall, held_flag;
    logic [31:0] held_val;
    logic [32:0] e;
    vt[0]  = '{6'd0, 1'b0, 5'd4,  32'h0,  32'h00000001, 2'b00, 5'd4,  32'h00000010, 1'b0};
    vt[1]  = '{6'd7, 1'b0, 5'd0,  32'h23, 32'h80000000, 2'b10, 5'd3,  32'hF0000000, 1'b0};
    vt[2]  = '{6'd2, 1'b1, 5'd8,  32'h0,  32'h12345678, 2'b11, 5'd8,  32'h78123456, 1'b0};
    vt[3]  = '{6'd0, 1'b1, 5'd8,  32'h0,  32'h12345678, 2'b11, 5'd24, 32'h34567812, 1'b0};
    vt[4]  = '{6'd0, 1'b1, 5'd0,  32'h0,  32'h12345678, 2'b11, 5'd0,  32'h12345678, 1'b0};
    vt[5]  = '{6'h20, 1'b0, 5'd5, 32'h0,  32'hDEADBEEF, 2'b00, 5'd0,  32'h00000000, 1'b1};
    vt[6]  = '{6'd2, 1'b0, 5'd31, 32'h0,  32'h80000000, 2'b01, 5'd31, 32'h00000001, 1'b0};
    vt[7]  = '{6'd4, 1'b1, 5'd0,  32'h1F, 32'h80000001, 2'b11, 5'd1,  32'hC0000000, 1'b0};
    vt[8]  = '{6'd3, 1'b0, 5'd0,  32'h0,  32'h80000000, 2'b10, 5'd0,  32'h80000000, 1'b0};
    vt[9]  = '{6'd6, 1'b1, 5'd9,  32'h44, 32'h0000000F, 2'b11, 5'd4,  32'hF0000000, 1'b0};
    vt[10] = '{6'd1, 1'b1, 5'd7,  32'h3,  32'hFFFFFFFF, 2'b00, 5'd0,  32'h00000000, 1'b1};
    vt[11] = '{6'd3, 1'b1, 5'd4,  32'h0,  32'h80000000, 2'b10, 5'd4,  32'hF8000000, 1'b0};
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_shift_op", 32'(shift_op), 32'd0);
    chk("rst_sa", 32'(SA), 32'd0);
    chk("rst_data", data, 32'd0);
    reset = 0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    k = 0; got = 0; lowcnt = 0; stall = 0; held_flag = 0; held_val = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      in_valid = k < 4; funct = 0; rot = 0; shamt = 5'(k + 1); rt_val = 1;
      if (out_valid && lowcnt < 3) begin out_ready = 0; lowcnt++; end else out_ready = 1;
      @(negedge clk);
      if (!in_ready) stall = 1;
      if (out_valid && !out_ready) begin
        if (held_flag != 0) chk("bp_hold", out_result, held_val);
        held_val = out_result; held_flag = 1;
      end else held_flag = 0;
      if (out_valid && out_ready) begin chk("bp_order", out_result, 32'd1 << (got + 1)); got++; end
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_count", 32'(got), 32'd4);
    chk("bp_stall_seen", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);
    in_valid = 1; funct = 0; rot = 0; shamt = 2; rt_val = 3; out_ready = 0;
    @(posedge clk); #1;
    shamt = 3;
    @(posedge clk); #1;
    in_valid = 0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    #2 reset = 1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s1_valid", 32'(dut.s1_valid), 32'd0);
    chk("mid_rst_out_result", out_result, 32'd0);
    chk("mid_rst_data", data, 32'd0);
    chk("mid_rst_sa", 32'(SA), 32'd0);
    @(posedge clk); #1;
    reset = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("post_rst_no_out", 32'(out_valid), 32'd0);
    run_vec(vt[6], "post_rst_srl");
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      rot = 1'($urandom); shamt = 5'($urandom); rs_val = $urandom; rt_val = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("rnd_res", out_result, e[31:0]);
          chk("rnd_ill", 32'(out_illegal), 32'(e[32]));
        end
      end
      if (in_valid && in_ready) q.push_back(model(funct, rot, shamt, rs_val, rt_val));
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("drain_res", out_result, e[31:0]);
        chk("drain_ill", 32'(out_illegal), 32'(e[32]));
      end
      @(posedge clk); #1;
    end
    chk("rnd_all_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
